// File: rtl/watch_time_tx_formatter_if.sv
// rtl/watch_time_tx_formatter_if.sv - TX FIFO push port between the time formatter and the UART TX FIFO
interface watch_time_tx_formatter_if;
    logic       push;
    logic [7:0] tx_data;
    logic       tx_full;

    modport master (output push, output tx_data, input tx_full);
    modport slave  (input push, input tx_data, output tx_full);
endinterface

// File: rtl/watch_time_tx_formatter.sv
// rtl/watch_time_tx_formatter.sv - snapshots watch time on req and pushes "HH:MM:SS.CC"[CR LF] to the TX FIFO
module watch_time_tx_formatter #(
    parameter bit ADD_CRLF = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req,
    input  logic [4:0]                        hour,
    input  logic [5:0]                        min,
    input  logic [5:0]                        sec,
    input  logic [6:0]                        msec,
    watch_time_tx_formatter_if.master         fifo,
    output logic                              busy,
    output logic                              done
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [3:0] LAST_IDX = ADD_CRLF ? 4'd12 : 4'd10;

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [4:0] snap_hour;
    logic [5:0] snap_min;
    logic [5:0] snap_sec;
    logic [6:0] snap_msec;
    logic       done_q, done_d;
    logic       load;
    logic       push_c;
    logic [7:0] frame_byte;

    // Out-of-range values are encoded by the same arithmetic, so tens may exceed 9.
    function automatic logic [7:0] tens_ch(input logic [6:0] v);
        logic [6:0] t;
        t = v / 7'd10;
        return 8'h30 + {1'b0, t};
    endfunction

    function automatic logic [7:0] ones_ch(input logic [6:0] v);
        logic [6:0] o;
        o = v % 7'd10;
        return 8'h30 + {1'b0, o};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= 4'd0;
            snap_hour <= 5'd0;
            snap_min  <= 6'd0;
            snap_sec  <= 6'd0;
            snap_msec <= 7'd0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            if (load) begin
                snap_hour <= hour;
                snap_min  <= min;
                snap_sec  <= sec;
                snap_msec <= msec;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        load    = 1'b0;
        push_c  = (state_q == SEND) && !fifo.tx_full;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = SEND;
                    idx_d   = 4'd0;
                    load    = 1'b1;
                end
            end
            SEND: begin
                if (push_c) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = 4'd0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        frame_byte = 8'h00;
        case (idx_q)
            4'd0:    frame_byte = tens_ch({2'b00, snap_hour});
            4'd1:    frame_byte = ones_ch({2'b00, snap_hour});
            4'd2:    frame_byte = 8'h3A;
            4'd3:    frame_byte = tens_ch({1'b0, snap_min});
            4'd4:    frame_byte = ones_ch({1'b0, snap_min});
            4'd5:    frame_byte = 8'h3A;
            4'd6:    frame_byte = tens_ch({1'b0, snap_sec});
            4'd7:    frame_byte = ones_ch({1'b0, snap_sec});
            4'd8:    frame_byte = 8'h2E;
            4'd9:    frame_byte = tens_ch(snap_msec);
            4'd10:   frame_byte = ones_ch(snap_msec);
            4'd11:   frame_byte = 8'h0D;
            4'd12:   frame_byte = 8'h0A;
            default: frame_byte = 8'h00;
        endcase
    end

    always_comb begin
        fifo.push    = push_c;
        fifo.tx_data = (state_q == SEND) ? frame_byte : 8'h00;
        busy         = (state_q == SEND);
        done         = done_q;
    end

endmodule
